// File: rtl/sar_adc_ctrl_if.sv
// sar_adc_ctrl_if - request/comparator/result bundle of the SAR controller
// master: requester + comparator side, slave: controller side
interface sar_adc_ctrl_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic             cmp_in;
   logic [WIDTH-1:0] ref_out;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (
      output start,
      output cmp_in,
      input  ref_out,
      input  busy,
      input  done,
      input  result
   );

   modport slave (
      input  start,
      input  cmp_in,
      output ref_out,
      output busy,
      output done,
      output result
   );
endinterface

// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl - successive-approximation controller, MSB first
// Macro SAR_CTRL_CONT_EN: start is a level enable, back-to-back conversions
module sar_adc_ctrl #(
   parameter int WIDTH  = 4,
   parameter int SETTLE = 2
) (
   input logic           clk,
   input logic           rst_n,
   sar_adc_ctrl_if.slave bus
);
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] MSB  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] REF0 = MSB - ONE;

   typedef enum logic [1:0] {
      IDLE,
      TRIAL,
      FINISH
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] ref_q;
   logic [WIDTH-1:0] result_q;
   logic [WIDTH-1:0] code_q;
   logic [WIDTH-1:0] bit_q;
   logic [CW-1:0]    cnt_q;
   logic             busy_q;
   logic             done_q;

   logic             go_d;
   logic             sample_d;
   logic             last_d;
   logic [WIDTH-1:0] code_d;
   logic [WIDTH-1:0] bit_d;
   logic [WIDTH-1:0] ref_d;

`ifdef SAR_CTRL_CONT_EN
   assign go_d = bus.start;
`else
   logic start_q;

   // registered copy of start so only its rising edge requests a conversion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) start_q <= 1'b0;
      else        start_q <= bus.start;
   end

   assign go_d = bus.start & ~start_q;
`endif

   // commit the trial bit on the comparator decision; next ref is T-1
   always_comb begin
      sample_d = (cnt_q == CW'(SETTLE - 1));
      last_d   = bit_q[0];
      code_d   = bus.cmp_in ? (code_q | bit_q) : code_q;
      bit_d    = bit_q >> 1;
      ref_d    = (code_d | bit_d) - ONE;
   end

   // conversion FSM; all outputs registered here
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         ref_q    <= '0;
         result_q <= '0;
         code_q   <= '0;
         bit_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE, FINISH: begin
               state_q <= IDLE;
               if (go_d) begin
                  state_q <= TRIAL;
                  code_q  <= '0;
                  bit_q   <= MSB;
                  ref_q   <= REF0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            TRIAL: begin
               cnt_q <= cnt_q + CW'(1);
               if (sample_d) begin
                  code_q <= code_d;
                  if (!last_d) begin
                     bit_q <= bit_d;
                     ref_q <= ref_d;
                     cnt_q <= '0;
                  end else begin
                     result_q <= code_d;
                     done_q   <= 1'b1;
                     busy_q   <= 1'b0;
                     state_q  <= FINISH;
`ifdef SAR_CTRL_CONT_EN
                     if (bus.start) begin
                        state_q <= TRIAL;
                        code_q  <= '0;
                        bit_q   <= MSB;
                        ref_q   <= REF0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                     end
`endif
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.ref_out = ref_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.result  = result_q;
endmodule
